// File: rtl/data_integrity_checker.sv
// Scoreboard-style checker for a DDR FIFO path: buffers written words, compares read-back
// words in order, and reports latency, counts, first-mismatch details and FIFO misuse.
module data_integrity_checker #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic [31:0]       finish_cycle_num,
    output logic [31:0]       checked_cnt,
    output logic [ERR_W-1:0]  error_cnt,
    output logic [31:0]       first_err_index,
    output logic [DATA_W-1:0] data_differ,
    output logic              overflow,
    output logic              underflow,
    output logic [1:0]        state
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        CHECK   = 2'd2,
        FAULT   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [31:0]         finish_q, finish_d;
    logic [31:0]         checked_q, checked_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [31:0]         first_idx_q, first_idx_d;
    logic [DATA_W-1:0]   differ_q, differ_d;
    logic                first_seen_q, first_seen_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic                fifo_empty, fifo_full;
    logic                push_en, pop_en;
    logic                ovf_evt, udf_evt;
    logic [DATA_W-1:0]   head_data;
    logic                mismatch;

    // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Decisions use pre-edge occupancy, so a push into an empty FIFO cannot feed a same-cycle pop.
    assign push_en  = wr_data_valid && !fifo_full;
    assign pop_en   = rd_data_valid && !fifo_empty;
    assign ovf_evt  = wr_data_valid && fifo_full;
    assign udf_evt  = rd_data_valid && fifo_empty;

    assign head_data = mem_q[rd_ptr_q[AW-1:0]];
    assign mismatch  = pop_en && (head_data != rd_data);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        finish_d     = finish_q;
        checked_d    = checked_q;
        err_d        = err_q;
        first_idx_d  = first_idx_q;
        differ_d     = differ_q;
        first_seen_d = first_seen_q;
        ovf_d        = ovf_q | ovf_evt;
        udf_d        = udf_q | udf_evt;

        if (push_en) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_en) begin
            rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
            checked_d = checked_q + 32'd1;
        end

        if (mismatch) begin
            if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + ERR_W'(1);
            end
            if (!first_seen_q) begin
                first_seen_d = 1'b1;
                first_idx_d  = checked_q;
                differ_d     = head_data ^ rd_data;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (wr_data_valid) begin
                    state_d  = WAIT_RD;
                    finish_d = 32'd1;
                end
            end
            WAIT_RD: begin
                if (rd_data_valid) begin
                    state_d = CHECK;
                end else if (finish_q != 32'hFFFF_FFFF) begin
                    finish_d = finish_q + 32'd1;
                end
            end
            CHECK:   state_d = CHECK;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (ovf_evt || udf_evt) begin
            state_d = FAULT;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            finish_q     <= '0;
            checked_q    <= '0;
            err_q        <= '0;
            first_idx_q  <= '0;
            differ_q     <= '0;
            first_seen_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            finish_q     <= finish_d;
            checked_q    <= checked_d;
            err_q        <= err_d;
            first_idx_q  <= first_idx_d;
            differ_q     <= differ_d;
            first_seen_q <= first_seen_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    // NOTE: the storage array has no reset; resetting the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign finish_cycle_num = finish_q;
    assign checked_cnt      = checked_q;
    assign error_cnt        = err_q;
    assign first_err_index  = first_idx_q;
    assign data_differ      = differ_q;
    assign overflow         = ovf_q;
    assign underflow        = udf_q;
    assign state            = state_q;

endmodule

// File: tb/tb_data_integrity_checker.sv
// Directed bench for data_integrity_checker: a default-depth and a DEPTH=4 instance share stimulus;
// a monitor pops queued per-read expectations and directed end-of-test checks use hand-computed constants.
module tb_data_integrity_checker;

    localparam int DW = 48;
    localparam int EW = 16;

    typedef struct {
        logic [31:0]   checked;
        logic [EW-1:0] errors;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_data_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          rd_data_valid = 1'b0;

    logic [31:0]   b_fcn, b_chk, b_fei, s_fcn, s_chk, s_fei;
    logic [EW-1:0] b_err, s_err;
    logic [DW-1:0] b_diff, s_diff;
    logic          b_ovf, b_udf, s_ovf, s_udf;
    logic [1:0]    b_state, s_state;

    logic [31:0]   m_fcn, m_chk, m_fei;
    logic [EW-1:0] m_err;
    logic [DW-1:0] m_diff;
    logic          m_ovf, m_udf;
    logic [1:0]    m_state;

    bit            sel_small = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;

    logic [DW-1:0] model_q[$];
    exp_t          exp_q[$];
    logic [31:0]   exp_checked = 0;
    logic [EW-1:0] exp_err = 0;

    always #5 clk = ~clk;

    data_integrity_checker #(.DATA_W(DW), .ERR_W(EW)) u_big (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .finish_cycle_num(b_fcn), .checked_cnt(b_chk), .error_cnt(b_err),
        .first_err_index(b_fei), .data_differ(b_diff),
        .overflow(b_ovf), .underflow(b_udf), .state(b_state)
    );

    data_integrity_checker #(.DATA_W(DW), .DEPTH(4), .ERR_W(EW)) u_small (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .finish_cycle_num(s_fcn), .checked_cnt(s_chk), .error_cnt(s_err),
        .first_err_index(s_fei), .data_differ(s_diff),
        .overflow(s_ovf), .underflow(s_udf), .state(s_state)
    );

    assign m_fcn   = sel_small ? s_fcn   : b_fcn;
    assign m_chk   = sel_small ? s_chk   : b_chk;
    assign m_err   = sel_small ? s_err   : b_err;
    assign m_fei   = sel_small ? s_fei   : b_fei;
    assign m_diff  = sel_small ? s_diff  : b_diff;
    assign m_ovf   = sel_small ? s_ovf   : b_ovf;
    assign m_udf   = sel_small ? s_udf   : b_udf;
    assign m_state = sel_small ? s_state : b_state;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One cycle of stimulus; the expected post-edge counts for a read are queued for the monitor.
    task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit rv, input logic [DW-1:0] rd);
        int            depth;
        int            size0;
        logic [DW-1:0] head;
        exp_t          e;
        depth = sel_small ? 4 : 1024;
        wr_data_valid = wv;
        wr_data = wd;
        rd_data_valid = rv;
        rd_data = rd;
        size0 = model_q.size();
        if (rv) begin
            if (size0 != 0) begin
                head = model_q.pop_front();
                exp_checked++;
                if (head != rd && exp_err != {EW{1'b1}}) exp_err++;
            end
            e.checked = exp_checked;
            e.errors = exp_err;
            exp_q.push_back(e);
        end
        if (wv && size0 < depth) model_q.push_back(wd);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wr_data_valid = 1'b0;
        rd_data_valid = 1'b0;
    endtask

    task automatic clear_model();
        model_q.delete();
        exp_checked = 0;
        exp_err = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_fcn"},   m_fcn,   0);
        check({tag, "_chk"},   m_chk,   0);
        check({tag, "_err"},   m_err,   0);
        check({tag, "_fei"},   m_fei,   0);
        check({tag, "_diff"},  m_diff,  0);
        check({tag, "_ovf"},   m_ovf,   0);
        check({tag, "_udf"},   m_udf,   0);
        check({tag, "_state"}, m_state, 0);
    endtask

    // Stream: write 0..n-1 from cycle 0, read 0..n-1 from cycle lat; bad_idx gets XOR 1.
    task automatic stream(input int n, input int lat, input int bad_idx);
        logic [DW-1:0] rv_word;
        for (int c = 0; c < n + lat; c++) begin
            rv_word = DW'(c - lat);
            if (c - lat == bad_idx) rv_word = rv_word ^ 48'h1;
            drive(c < n, DW'(c), c >= lat, rv_word);
        end
        quiet();
    endtask

    // Monitor: after every edge that carried a read, pop and compare the queued counts.
    initial begin
        bit   v;
        exp_t e;
        forever begin
            @(posedge clk);
            v = rd_data_valid && !rst;
            @(negedge clk);
            if (v) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mon_queue: read result seen with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    check("mon_checked", m_chk, e.checked);
                    check("mon_errors", m_err, e.errors);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;

        // Clean 100-word stream, read latency 10.
        sel_small = 1'b0;
        do_reset();
        check_zero("reset");
        stream(100, 10, -1);
        @(negedge clk);
        check("t1_fcn", m_fcn, 10);
        check("t1_chk", m_chk, 100);
        check("t1_err", m_err, 0);
        check("t1_state", m_state, 2);
        check("t1_ovf", m_ovf, 0);
        check("t1_udf", m_udf, 0);

        // Word 37 corrupted.
        do_reset();
        stream(100, 10, 37);
        @(negedge clk);
        check("t2_chk", m_chk, 100);
        check("t2_err", m_err, 1);
        check("t2_fei", m_fei, 37);
        check("t2_diff", m_diff, 48'h000000000001);
        check("t2_state", m_state, 2);

        // DEPTH=4 overflow, then drain the four stored words.
        sel_small = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(i), 1'b0, '0);
        quiet();
        @(negedge clk);
        check("t3_ovf", m_ovf, 1);
        check("t3_state", m_state, 3);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, DW'(i));
        quiet();
        @(negedge clk);
        check("t3_err", m_err, 0);
        check("t3_chk", m_chk, 4);
        check("t3_udf", m_udf, 0);
        check("t3_state_hold", m_state, 3);

        // Read with no prior write.
        sel_small = 1'b0;
        do_reset();
        drive(1'b0, '0, 1'b1, 48'h123);
        quiet();
        @(negedge clk);
        check("t4_udf", m_udf, 1);
        check("t4_chk", m_chk, 0);
        check("t4_state", m_state, 3);
        check("t4_ovf", m_ovf, 0);

        // DEPTH=4 steady state with occupancy 2: pointers wrap several times.
        sel_small = 1'b1;
        do_reset();
        drive(1'b1, 48'd0, 1'b0, '0);
        drive(1'b1, 48'd1, 1'b0, '0);
        for (int k = 0; k < 20; k++) drive(1'b1, DW'(k + 2), 1'b1, DW'(k));
        quiet();
        @(negedge clk);
        check("t5_chk", m_chk, 20);
        check("t5_err", m_err, 0);
        check("t5_ovf", m_ovf, 0);
        check("t5_udf", m_udf, 0);
        check("t5_state", m_state, 2);
        check("t5_fcn", m_fcn, 2);

        // Reset mid-stream with valids asserted, then a fresh clean stream.
        sel_small = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) drive(1'b1, DW'(c), c >= 5, DW'(c - 5));
        wr_data_valid = 1'b1;
        rd_data_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        quiet();
        clear_model();
        check_zero("midrst");
        stream(10, 3, -1);
        @(negedge clk);
        check("t6_chk", m_chk, 10);
        check("t6_err", m_err, 0);
        check("t6_fcn", m_fcn, 3);
        check("t6_state", m_state, 2);

        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
